key_matrix_scan: RTL and testbench
==================================

KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1024, cycles each column is driven before sampling (min 4).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive differing samples needed to accept a key change (1..15).
REQ-003 SHALL have port clk12MHz  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port kcol  output  4  column drive, active-low, exactly one bit low at any time.
REQ-006 SHALL have port krow  input  4  row sense, active-low (external pull-ups), asynchronous to clk12MHz.
REQ-007 SHALL have port key_state  output  16  debounced pressed map, bit col*4+row, 1 = pressed.
REQ-008 SHALL have port ev_valid  output  1  event FIFO non-empty.
REQ-009 SHALL have port ev_ready  input  1  consumer accepts head event when high with ev_valid.
REQ-010 SHALL have port ev_code  output  4  key index (col*4+row) of head event.
REQ-011 SHALL have port ev_press  output  1  1 = press, 0 = release, head event.
REQ-012 SHALL have port ev_overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-013 SHALL have port ev_overflow_clr  input  1  clears ev_overflow.

Function
REQ-014 krow SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Scan FSM states: DRIVE, EVAL0, EVAL1, EVAL2, EVAL3; column index col (2 bits) persists across states.
REQ-016 DRIVE: kcol = ~(1<<col) held for SCAN_DIV cycles; on the last DRIVE cycle the inverted synchronized krow SHALL be latched as sample[3:0], then go to EVAL0.
REQ-017 EVALr processes row r of the latched sample, one row per cycle, ascending; kcol unchanged during EVAL.
REQ-018 EVAL3 SHALL go to DRIVE with col+1, wrapping 3 -> 0; full scan period = 4*(SCAN_DIV+4) cycles.
REQ-019 Per key 4-bit counter: sample == key_state bit -> counter := 0; differs -> counter+1; on reaching DEBOUNCE_SCANS, key_state bit toggles and counter := 0.
REQ-020 Each key_state toggle SHALL push {code, new value} into the event FIFO in the same EVAL cycle.
REQ-021 Event FIFO: depth 4, first-word-fall-through; ev_code/ev_press valid whenever ev_valid; pop on ev_valid & ev_ready.
REQ-022 Push when full without simultaneous pop: event dropped, ev_overflow set, key_state still updated.
REQ-023 Push and pop in the same cycle when full: both succeed, no overflow.
REQ-024 Push into empty FIFO: ev_valid high the following cycle.
REQ-025 ev_overflow_clr concurrent with a new drop: ev_overflow remains 1 (set wins).
REQ-026 Multiple keys changing in one column: events ordered by ascending row.

Reset
REQ-027 Reset SHALL asynchronously force: state DRIVE, col 0, kcol = 4'b1110, divider 0, sample 0, all debounce counters 0, key_state 0, FIFO empty (ev_valid 0), ev_overflow 0, synchronizer flops 1 (idle).
REQ-028 Reset mid-scan or with pending events SHALL discard all state; no events generated for keys held through reset until they debounce as pressed after release of reset.

Structure
REQ-029 Shared package: key code width (4), column/row counts (4), FSM state encoding, FIFO depth constant.
REQ-030 Event FIFO SHALL be a separate sub-module key_event_fifo (width 5, depth 4, full/empty/push/pop).

Verification
REQ-031 SCAN_DIV=8, DEBOUNCE_SCANS=3: hold key col 2 row 1 low through 3 scans -> key_state[9]=1, one event code 9 press=1; release 3 scans -> code 9 press=0.
REQ-032 Glitch: key 5 low for 2 scans then high -> no event, key_state[5] stays 0.
REQ-033 Press keys 0,1,2,3 (col 0) simultaneously, ev_ready=0 -> FIFO holds codes 0,1,2,3 in order, ev_overflow=0; press key 4 -> dropped, ev_overflow=1, key_state[4]=1.
REQ-034 Full FIFO, ev_ready=1 in the cycle of a new push -> no overflow, head advances, new event at tail.
REQ-035 Assert reset mid-DRIVE with 2 events queued -> kcol=4'b1110, ev_valid=0, key_state=0 immediately (asynchronous).
REQ-036 kcol check every cycle: exactly one zero, sequence 1110,1101,1011,0111,1110, each held SCAN_DIV+4 cycles.

Source files
------------

// File: rtl/key_matrix_scan_pkg.sv
// Shared constants, scan FSM encoding and event payload for the 4x4 key matrix scanner.
package key_matrix_scan_pkg;

  localparam int unsigned NUM_COLS   = 4;
  localparam int unsigned NUM_ROWS   = 4;
  localparam int unsigned NUM_KEYS   = NUM_COLS * NUM_ROWS;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned COL_W      = 2;
  localparam int unsigned ROW_W      = 2;
  localparam int unsigned DEB_W      = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned EV_W       = CODE_W + 1;

  typedef enum logic [2:0] {
    ST_DRIVE = 3'd0,
    ST_EVAL0 = 3'd1,
    ST_EVAL1 = 3'd2,
    ST_EVAL2 = 3'd3,
    ST_EVAL3 = 3'd4
  } scan_state_t;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              press;
  } key_event_t;

endpackage

// File: rtl/key_matrix_scan_if.sv
// Key event stream: FWFT head event, ready/valid pop, sticky overflow with clear.
interface key_matrix_scan_if;
  import key_matrix_scan_pkg::*;

  logic              ev_valid;
  logic              ev_ready;
  logic [CODE_W-1:0] ev_code;
  logic              ev_press;
  logic              ev_overflow;
  logic              ev_overflow_clr;

  modport master (
    output ev_valid, ev_code, ev_press, ev_overflow,
    input  ev_ready, ev_overflow_clr
  );

  modport slave (
    input  ev_valid, ev_code, ev_press, ev_overflow,
    output ev_ready, ev_overflow_clr
  );
endinterface

// File: rtl/key_event_fifo.sv
// Four-entry first-word-fall-through FIFO for key events; pop frees a slot for a same-cycle push.
module key_event_fifo
  import key_matrix_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  key_event_t din,
  input  logic       pop,
  output key_event_t dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  key_event_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == CNT_W'(0));
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: contents are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 key matrix scanner: column drive, synchronized row sampling, per-key debounce, event FIFO.
module key_matrix_scan
  import key_matrix_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1024,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                 clk12MHz,
  input  logic                 reset,
  output logic [NUM_COLS-1:0]  kcol,
  input  logic [NUM_ROWS-1:0]  krow,
  output logic [NUM_KEYS-1:0]  key_state,
  key_matrix_scan_if.master    ev
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  scan_state_t         state, state_next;
  logic [DIV_W-1:0]    div, div_next;
  logic [COL_W-1:0]    col, col_next;
  logic [ROW_W-1:0]    row;
  logic                eval_active;
  logic                sample_load;
  logic [NUM_ROWS-1:0] krow_meta, krow_sync;
  logic [NUM_ROWS-1:0] sample;
  logic [DEB_W-1:0]    deb_cnt [NUM_KEYS];
  logic [CODE_W-1:0]   key_idx;
  logic [DEB_W-1:0]    cnt_inc;
  logic                differs;
  logic                toggle;
  key_event_t          push_ev, head_ev;
  logic                fifo_full, fifo_empty;
  logic                pop, drop;

  // Rows are asynchronous to the clock; idle level is all-high.
  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      krow_meta <= '1;
      krow_sync <= '1;
    end else begin
      krow_meta <= krow;
      krow_sync <= krow_meta;
    end
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      state <= ST_DRIVE;
      div   <= '0;
      col   <= '0;
      kcol  <= 4'b1110;
    end else begin
      state <= state_next;
      div   <= div_next;
      col   <= col_next;
      kcol  <= ~(NUM_COLS'(1) << col_next);
    end
  end

  always_comb begin
    state_next  = state;
    div_next    = div;
    col_next    = col;
    sample_load = 1'b0;
    eval_active = 1'b0;
    row         = '0;
    case (state)
      ST_DRIVE: begin
        if (div == DIV_W'(SCAN_DIV - 1)) begin
          div_next    = '0;
          sample_load = 1'b1;
          state_next  = ST_EVAL0;
        end else begin
          div_next = div + DIV_W'(1);
        end
      end
      ST_EVAL0: begin
        eval_active = 1'b1;
        row         = ROW_W'(0);
        state_next  = ST_EVAL1;
      end
      ST_EVAL1: begin
        eval_active = 1'b1;
        row         = ROW_W'(1);
        state_next  = ST_EVAL2;
      end
      ST_EVAL2: begin
        eval_active = 1'b1;
        row         = ROW_W'(2);
        state_next  = ST_EVAL3;
      end
      ST_EVAL3: begin
        eval_active = 1'b1;
        row         = ROW_W'(3);
        state_next  = ST_DRIVE;
        col_next    = col + COL_W'(1);
      end
      default: state_next = ST_DRIVE;
    endcase
  end

  // Debounce decision for the key currently under evaluation.
  always_comb begin
    key_idx = {col, row};
    differs = sample[row] != key_state[key_idx];
    cnt_inc = deb_cnt[key_idx] + DEB_W'(1);
    toggle  = eval_active & differs & (cnt_inc == DEB_W'(DEBOUNCE_SCANS));
    push_ev = '{code: key_idx, press: ~key_state[key_idx]};
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      sample    <= '0;
      key_state <= '0;
      for (int i = 0; i < NUM_KEYS; i++) deb_cnt[i] <= '0;
    end else begin
      if (sample_load) sample <= ~krow_sync;
      if (eval_active) begin
        if (!differs) begin
          deb_cnt[key_idx] <= '0;
        end else if (toggle) begin
          deb_cnt[key_idx]   <= '0;
          key_state[key_idx] <= ~key_state[key_idx];
        end else begin
          deb_cnt[key_idx] <= cnt_inc;
        end
      end
    end
  end

  assign pop  = ev.ev_ready & ~fifo_empty;
  assign drop = toggle & fifo_full & ~pop;

  key_event_fifo u_fifo (
    .clk   (clk12MHz),
    .rst   (reset),
    .push  (toggle),
    .din   (push_ev),
    .pop   (pop),
    .dout  (head_ev),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev.ev_valid = ~fifo_empty;
  assign ev.ev_code  = head_ev.code;
  assign ev.ev_press = head_ev.press;

  // A new drop outranks a concurrent clear.
  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset)                   ev.ev_overflow <= 1'b0;
    else if (drop)               ev.ev_overflow <= 1'b1;
    else if (ev.ev_overflow_clr) ev.ev_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench: keyboard matrix model on kcol/krow, debounce, event FIFO and reset scenarios.
module tb_key_matrix_scan;

  localparam int unsigned SCAN = 48;  // 4*(8+4) cycles

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  kcol;
  logic [3:0]  krow;
  logic [15:0] key_state;
  logic [15:0] keys_down = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  key_matrix_scan_if ev_bus ();

  key_matrix_scan #(.SCAN_DIV(8), .DEBOUNCE_SCANS(3)) dut (
    .clk12MHz  (clk),
    .reset     (reset),
    .kcol      (kcol),
    .krow      (krow),
    .key_state (key_state),
    .ev        (ev_bus.master)
  );

  always #5 clk = ~clk;

  // Pressed key at (c,r) pulls row r low while column c is driven low.
  always_comb begin
    krow = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!kcol[c] && keys_down[c*4+r]) krow[r] = 1'b0;
  end

  task automatic do_reset();
    reset = 1'b1;
    keys_down = '0;
    ev_bus.ev_ready = 1'b0;
    ev_bus.ev_overflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  task automatic pop_one();
    ev_bus.ev_ready = 1'b1;
    @(negedge clk);
    ev_bus.ev_ready = 1'b0;
  endtask

  // Returns at the negedge of the first cycle of column 0 DRIVE.
  task automatic align_col0();
    logic [3:0] prev;
    int         guard;
    prev  = kcol;
    guard = 0;
    @(negedge clk);
    while (!(kcol == 4'b1110 && prev == 4'b0111) && guard < 200) begin
      prev = kcol;
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      n_checks++;
      $display("FAIL align_col0: no column wrap seen within 200 cycles, kcol=%b", kcol);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (kcol !== 4'b1110) $display("FAIL reset_kcol: got %b want 1110", kcol); else n_pass++;
    n_checks++; if (key_state !== 16'h0) $display("FAIL reset_key_state: got %h want 0000", key_state); else n_pass++;
    n_checks++; if (ev_bus.ev_valid !== 1'b0) $display("FAIL reset_ev_valid: got %b want 0", ev_bus.ev_valid); else n_pass++;
    n_checks++; if (ev_bus.ev_overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", ev_bus.ev_overflow); else n_pass++;
  endtask

  task automatic test_kcol_sequence();
    logic [3:0] one;
    logic [3:0] exp;
    one = 4'b0001;
    align_col0();
    for (int k = 0; k < 2 * SCAN; k++) begin
      exp = ~(one << ((k / 12) % 4));
      n_checks++;
      if (kcol !== exp) $display("FAIL kcol_seq cycle %0d: got %b want %b", k, kcol, exp);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_press_release();
    do_reset();
    keys_down = 16'h0200;
    wait_scans(4);
    n_checks++; if (key_state !== 16'h0200) $display("FAIL press9_state: got %h want 0200", key_state); else n_pass++;
    n_checks++; if (ev_bus.ev_valid !== 1'b1) $display("FAIL press9_valid: got %b want 1", ev_bus.ev_valid); else n_pass++;
    n_checks++; if (ev_bus.ev_code !== 4'd9) $display("FAIL press9_code: got %0d want 9", ev_bus.ev_code); else n_pass++;
    n_checks++; if (ev_bus.ev_press !== 1'b1) $display("FAIL press9_press: got %b want 1", ev_bus.ev_press); else n_pass++;
    pop_one();
    n_checks++; if (ev_bus.ev_valid !== 1'b0) $display("FAIL press9_single_event: valid %b want 0", ev_bus.ev_valid); else n_pass++;
    keys_down = 16'h0000;
    wait_scans(4);
    n_checks++; if (key_state !== 16'h0000) $display("FAIL release9_state: got %h want 0000", key_state); else n_pass++;
    n_checks++; if (ev_bus.ev_code !== 4'd9 || ev_bus.ev_valid !== 1'b1) $display("FAIL release9_code: valid %b code %0d want 1/9", ev_bus.ev_valid, ev_bus.ev_code); else n_pass++;
    n_checks++; if (ev_bus.ev_press !== 1'b0) $display("FAIL release9_press: got %b want 0", ev_bus.ev_press); else n_pass++;
    pop_one();
    n_checks++; if (ev_bus.ev_valid !== 1'b0) $display("FAIL release9_drain: valid %b want 0", ev_bus.ev_valid); else n_pass++;
  endtask

  task automatic test_glitch();
    do_reset();
    align_col0();
    keys_down = 16'h0020;
    wait_scans(2);
    keys_down = 16'h0000;
    wait_scans(4);
    n_checks++; if (key_state !== 16'h0000) $display("FAIL glitch_state: got %h want 0000", key_state); else n_pass++;
    n_checks++; if (ev_bus.ev_valid !== 1'b0) $display("FAIL glitch_event: valid %b want 0", ev_bus.ev_valid); else n_pass++;
  endtask

  task automatic test_fifo_overflow();
    do_reset();
    keys_down = 16'h000F;
    wait_scans(4);
    n_checks++; if (ev_bus.ev_valid !== 1'b1 || ev_bus.ev_code !== 4'd0) $display("FAIL fill_head: valid %b code %0d want 1/0", ev_bus.ev_valid, ev_bus.ev_code); else n_pass++;
    n_checks++; if (ev_bus.ev_overflow !== 1'b0) $display("FAIL fill_no_overflow: got %b want 0", ev_bus.ev_overflow); else n_pass++;
    keys_down = 16'h001F;
    wait_scans(4);
    n_checks++; if (ev_bus.ev_overflow !== 1'b1) $display("FAIL drop_overflow: got %b want 1", ev_bus.ev_overflow); else n_pass++;
    n_checks++; if (key_state !== 16'h001F) $display("FAIL drop_key_state: got %h want 001f", key_state); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ev_bus.ev_valid !== 1'b1 || ev_bus.ev_code !== 4'(i) || ev_bus.ev_press !== 1'b1)
        $display("FAIL order_%0d: valid %b code %0d press %b want 1/%0d/1", i, ev_bus.ev_valid, ev_bus.ev_code, ev_bus.ev_press, i);
      else n_pass++;
      pop_one();
    end
    n_checks++; if (ev_bus.ev_valid !== 1'b0) $display("FAIL drop_not_queued: valid %b code %0d want empty", ev_bus.ev_valid, ev_bus.ev_code); else n_pass++;
    ev_bus.ev_overflow_clr = 1'b1;
    @(negedge clk);
    ev_bus.ev_overflow_clr = 1'b0;
    n_checks++; if (ev_bus.ev_overflow !== 1'b0) $display("FAIL overflow_clr: got %b want 0", ev_bus.ev_overflow); else n_pass++;
  endtask

  // Fills the FIFO with keys 0..3, then presses key 8 so its toggle lands 128 cycles after alignment.
  task automatic setup_full_then_key8();
    do_reset();
    keys_down = 16'h000F;
    wait_scans(4);
    align_col0();
    keys_down = 16'h010F;
    repeat (128) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    setup_full_then_key8();
    n_checks++; if (key_state[8] !== 1'b0) $display("FAIL b2b_pre_toggle: key8 %b want 0", key_state[8]); else n_pass++;
    pop_one();
    n_checks++; if (key_state[8] !== 1'b1) $display("FAIL b2b_toggle: key8 %b want 1", key_state[8]); else n_pass++;
    n_checks++; if (ev_bus.ev_overflow !== 1'b0) $display("FAIL b2b_overflow: got %b want 0", ev_bus.ev_overflow); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp;
      exp = (i == 3) ? 4'd8 : 4'(i + 1);
      n_checks++;
      if (ev_bus.ev_valid !== 1'b1 || ev_bus.ev_code !== exp)
        $display("FAIL b2b_order_%0d: valid %b code %0d want 1/%0d", i, ev_bus.ev_valid, ev_bus.ev_code, exp);
      else n_pass++;
      pop_one();
    end
    n_checks++; if (ev_bus.ev_valid !== 1'b0) $display("FAIL b2b_drain: valid %b want 0", ev_bus.ev_valid); else n_pass++;
  endtask

  task automatic test_overflow_set_wins();
    setup_full_then_key8();
    ev_bus.ev_overflow_clr = 1'b1;
    @(negedge clk);
    ev_bus.ev_overflow_clr = 1'b0;
    n_checks++; if (ev_bus.ev_overflow !== 1'b1) $display("FAIL set_wins_overflow: got %b want 1", ev_bus.ev_overflow); else n_pass++;
    n_checks++; if (key_state[8] !== 1'b1) $display("FAIL set_wins_key8: got %b want 1", key_state[8]); else n_pass++;
    n_checks++; if (ev_bus.ev_code !== 4'd0) $display("FAIL set_wins_head: got %0d want 0", ev_bus.ev_code); else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    keys_down = 16'h0003;
    wait_scans(4);
    n_checks++; if (ev_bus.ev_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", ev_bus.ev_valid); else n_pass++;
    align_col0();
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_checks++; if (kcol !== 4'b1110) $display("FAIL mid_async_kcol: got %b want 1110", kcol); else n_pass++;
    n_checks++; if (ev_bus.ev_valid !== 1'b0) $display("FAIL mid_async_valid: got %b want 0", ev_bus.ev_valid); else n_pass++;
    n_checks++; if (key_state !== 16'h0000) $display("FAIL mid_async_state: got %h want 0000", key_state); else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (ev_bus.ev_valid !== 1'b0) $display("FAIL mid_post_valid: got %b want 0", ev_bus.ev_valid); else n_pass++;
    wait_scans(4);
    n_checks++; if (key_state !== 16'h0003) $display("FAIL mid_redebounce: got %h want 0003", key_state); else n_pass++;
    n_checks++; if (ev_bus.ev_valid !== 1'b1 || ev_bus.ev_code !== 4'd0) $display("FAIL mid_new_event: valid %b code %0d want 1/0", ev_bus.ev_valid, ev_bus.ev_code); else n_pass++;
  endtask

  initial begin
    ev_bus.ev_ready = 1'b0;
    ev_bus.ev_overflow_clr = 1'b0;
    test_reset();
    test_kcol_sequence();
    test_press_release();
    test_glitch();
    test_fifo_overflow();
    test_back_to_back();
    test_overflow_set_wins();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
